// File: rtl/wave_synth_pkg.sv
// wave_synth_pkg: waveform mode encoding shared by the wave_synth slice.
package wave_synth_pkg;
    typedef enum logic [1:0] {
        MODE_SAW_UP = 2'd0,
        MODE_SAW_DN = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SQR    = 2'd3
    } mode_t;
endpackage

// File: rtl/wave_synth_sample_divider.sv
// sample_divider: clock-enable generator, one tick every sample_div+1 enabled clocks.
module sample_divider #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] sample_div,
    output logic                 tick
);
    logic [DIV_WIDTH-1:0] div_cnt;

    assign tick = enable && (div_cnt == sample_div);

    // Lowering sample_div below div_cnt lets the counter run through its natural wrap.
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            div_cnt <= '0;
        else if (clear || tick)
            div_cnt <= '0;
        else if (enable)
            div_cnt <= div_cnt + 1'b1;
endmodule

// File: rtl/wave_synth.sv
// wave_synth: phase-accumulator waveform generator (saw/tri/square) on a divided sample tick.
// Optional phase sync input sync_in is added when WAVE_SYNTH_SYNC_EN is defined.
module wave_synth
    import wave_synth_pkg::*;
#(
    parameter int PHASE_WIDTH = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int DIV_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [OUT_WIDTH-1:0]   duty,
    input  logic [DIV_WIDTH-1:0]   sample_div,
    input  logic [PHASE_WIDTH-1:0] tune_word,
    input  logic                   tune_load,
`ifdef WAVE_SYNTH_SYNC_EN
    input  logic                   sync_in,
`endif
    output logic                   tune_busy,
    output logic [OUT_WIDTH-1:0]   wave_out,
    output logic                   sample_strobe,
    output logic                   wrap
);
    logic                   sync, tick, carry, apply;
    logic [PHASE_WIDTH-1:0] phase, active_tune, pending_tune, next_phase, map_phase;
    logic [OUT_WIDTH-1:0]   p, tri_v, sample;
    mode_t                  m;

`ifdef WAVE_SYNTH_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    sample_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear      (sync),
        .sample_div (sample_div),
        .tick       (tick)
    );

    assign {carry, next_phase} = {1'b0, phase} + {1'b0, active_tune};
    assign map_phase = sync ? '0 : next_phase;
    assign p         = map_phase[PHASE_WIDTH-1 -: OUT_WIDTH];
    assign tri_v     = {p[OUT_WIDTH-2:0], 1'b0} ^ {OUT_WIDTH{p[OUT_WIDTH-1]}};
    assign m         = mode_t'(mode);

    always_comb
        sample = m == MODE_SAW_UP ? p :
                 m == MODE_SAW_DN ? ~p :
                 m == MODE_TRI    ? tri_v : {OUT_WIDTH{p < duty}};

    // The wrapping tick still advances with the old increment; the swap lands at the same edge.
    assign apply = tune_busy && (sync || !enable || active_tune == '0 || (tick && carry));

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            phase         <= '0;
            active_tune   <= '0;
            pending_tune  <= '0;
            tune_busy     <= 1'b0;
            wave_out      <= '0;
            sample_strobe <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            if (sync || tick) begin
                phase    <= map_phase;
                wave_out <= sample;
            end
            sample_strobe <= sync || tick;
            wrap          <= !sync && tick && carry;
            if (apply)
                active_tune <= pending_tune;
            if (tune_load)
                pending_tune <= tune_word;
            if (tune_load)
                tune_busy <= 1'b1;
            else if (apply)
                tune_busy <= 1'b0;
        end
endmodule

// File: tb/tb_wave_synth.sv
// tb_wave_synth: scoreboard bench for wave_synth; expected samples queued by stimulus, popped on sample_strobe.
module tb_wave_synth;
    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, tune_load = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  duty = 8'd0, sample_div = 8'd0;
    logic [15:0] tune_word = 16'd0;
`ifdef WAVE_SYNTH_SYNC_EN
    logic        sync_in = 1'b0;
`endif
    logic        tune_busy, sample_strobe, wrap;
    logic [7:0]  wave_out;
    int          checks = 0, failures = 0;

    typedef struct {logic [7:0] w; logic wr; logic dc;} exp_t;
    exp_t q[$];

    wave_synth dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .mode          (mode),
        .duty          (duty),
        .sample_div    (sample_div),
        .tune_word     (tune_word),
        .tune_load     (tune_load),
`ifdef WAVE_SYNTH_SYNC_EN
        .sync_in       (sync_in),
`endif
        .tune_busy     (tune_busy),
        .wave_out      (wave_out),
        .sample_strobe (sample_strobe),
        .wrap          (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [7:0] w, input logic wr, input logic dc = 1'b0);
        q.push_back('{w, wr, dc});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; tune_load = 1'b0; mode = 2'd0; duty = 8'd0;
        sample_div = 8'd0; tune_word = 16'd0;
        q.delete();
        repeat (2) nxt();
        reset = 1'b1;
        nxt();
    endtask

    task automatic run_load(input int n, input logic [15:0] tw);
        enable = 1'b1; tune_word = tw; tune_load = 1'b1;
        nxt();
        tune_load = 1'b0;
        repeat (n - 1) nxt();
    endtask

    task automatic drain(input string name);
        enable = 1'b0; tune_load = 1'b0;
        repeat (3) nxt();
        chk(name, q.size(), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            if (sample_strobe) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: got wave_out %0h with empty queue at %0t", wave_out, $time);
                end else begin
                    e = q.pop_front();
                    if (!e.dc) chk("wave_out", wave_out, e.w);
                    chk("wrap", wrap, e.wr);
                end
            end else begin
                chk("wrap_no_strobe", wrap, 0);
            end
        end
    end

    logic [7:0] tri_tab [16] = '{8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0, 8'hFF,
                                 8'hDF, 8'hBF, 8'h9F, 8'h7F, 8'h5F, 8'h3F, 8'h1F, 8'h00};

    initial begin
        nxt();
        for (int i = 0; i < 6; i++) begin
            enable = 1'($urandom); tune_load = 1'($urandom); mode = 2'($urandom);
            duty = 8'($urandom); sample_div = 8'($urandom); tune_word = 16'($urandom);
            @(negedge clk);
            chk("reset_outputs", {wave_out, tune_busy, sample_strobe, wrap}, 0);
            nxt();
        end
        enable = 1'b0; tune_load = 1'b0; mode = 2'd0; duty = 8'd0; sample_div = 8'd0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_wave", wave_out, 0);
            chk("post_reset_busy", tune_busy, 0);
            nxt();
        end

        // saw-up, tick every clock, two full periods
        do_reset();
        push(8'h00, 1'b0); push(8'h00, 1'b0);
        for (int i = 1; i <= 32; i++) push(8'((i * 16) & 255), (i % 16) == 0);
        run_load(34, 16'h1000);
        drain("saw_drain");

        // divider cadence with an enable gap mid-count
        do_reset();
        sample_div = 8'd3;
        push(8'h10, 1'b0); push(8'h20, 1'b0);
        run_load(10, 16'h1000);
        enable = 1'b0; mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_wave", wave_out, 8'h20);
            nxt();
        end
        mode = 2'd0;
        push(8'h30, 1'b0); push(8'h40, 1'b0);
        enable = 1'b1;
        repeat (8) nxt();
        drain("div_drain");

        // triangle
        do_reset();
        mode = 2'd2;
        push(8'h00, 1'b0); push(8'h00, 1'b0);
        for (int i = 0; i < 16; i++) push(tri_tab[i], i == 15);
        run_load(18, 16'h1000);
        drain("tri_drain");

        // tune handshake: 0x2000 loaded at phase 0x5000 takes over after the wrap
        do_reset();
        push(8'h00, 1'b0); push(8'h00, 1'b0);
        for (int i = 1; i <= 15; i++) push(8'(i * 16), 1'b0);
        push(8'h00, 1'b1);
        for (int i = 1; i <= 7; i++) push(8'(i * 32), 1'b0);
        push(8'h00, 1'b1);
        for (int j = 0; j < 26; j++) begin
            enable = 1'b1;
            tune_load = (j == 0) || (j == 7);
            tune_word = (j == 0) ? 16'h1000 : 16'h2000;
            @(negedge clk);
            if (j >= 1 && j <= 20) chk("tune_busy", tune_busy, (j == 1) || (j >= 8 && j <= 17));
            nxt();
        end
        drain("tune_drain");

        // square at duty 0x40, then duty 0 for a full period
        do_reset();
        mode = 2'd3;
        push(8'h00, 1'b0, 1'b1); push(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) push(8'hFF, 1'b0);
        for (int i = 0; i < 12; i++) push(8'h00, 1'b0);
        push(8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) push(8'h00, 1'b0);
        push(8'h00, 1'b1);
        for (int j = 0; j < 34; j++) begin
            enable = 1'b1;
            tune_load = (j == 0);
            tune_word = 16'h1000;
            duty = (j < 18) ? 8'h40 : 8'h00;
            nxt();
        end
        drain("sqr_drain");

`ifdef WAVE_SYNTH_SYNC_EN
        // sync at phase 0x7000 restarts from phase 0 without a wrap
        do_reset();
        push(8'h00, 1'b0); push(8'h00, 1'b0);
        for (int i = 1; i <= 7; i++) push(8'(i * 16), 1'b0);
        push(8'h00, 1'b0);
        for (int i = 1; i <= 5; i++) push(8'(i * 16), 1'b0);
        for (int j = 0; j < 15; j++) begin
            enable = 1'b1;
            tune_load = (j == 0);
            tune_word = 16'h1000;
            sync_in = (j == 9);
            nxt();
        end
        sync_in = 1'b0;
        drain("sync_drain");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
